store_buffer: RTL and testbench

Posted-write buffer between the core's memory-stage signals and the data memory port. Stores are queued and retired into memory on cycles when the memory port is free. Loads go straight to memory and see pending stores through newest-first forwarding. The core stalls only when the buffer cannot accept a store or a load cannot be served.

---
 rtl/store_buffer_pkg.sv | 14 +
 rtl/store_buffer_match.sv | 36 +++
 rtl/store_buffer.sv | 126 ++++++++++++
 tb/tb_store_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared constants and entry type for the store buffer
package store_buffer_pkg;

    localparam int SB_W     = 32;
    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 3;
    localparam int SB_PW    = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [SB_W-1:0] addr;
        logic [SB_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// rtl/store_buffer_match.sv - newest-first address match over pending store entries
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int W     = SB_W,
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    entry_addr [DEPTH],
    input  logic [W-1:0]     entry_data [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [PW-1:0]    rd_ptr,
    input  logic [PW:0]      count,
    input  logic [AW-1:0]    lookup_addr,
    output logic             hit,
    output logic [W-1:0]     data
);

    // Walk entries from oldest to newest so the last match seen is the newest one,
    // equivalent to scanning backwards from wr_ptr-1 and stopping at the first hit.
    always_comb begin
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((PW+1)'(k) < count && valid[idx] && entry_addr[idx] == lookup_addr) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer; STORE_BUFFER_FWD_EN enables load forwarding
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int W     = SB_W,
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         MEM_RE,
    input  logic         MEM_WE,
    input  logic [W-1:0] MEM_A,
    input  logic [W-1:0] MEM_WD,
    output logic [W-1:0] MEM_RD,
    output logic         STALL,
    output logic         EMPTY,
    input  logic         DM_GNT,
    output logic         DM_WE,
    output logic [W-1:0] DM_A,
    output logic [W-1:0] DM_WD,
    input  logic [W-1:0] DM_RD
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]     e_addr [DEPTH];
    logic [W-1:0]     e_data [DEPTH];
    logic [AW-1:0]    e_addr_lo [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    logic             full;
    logic             nonempty;
    logic             hit;
    logic [W-1:0]     fwd_data;
    logic             drain;
    logic             push;

    // Occupancy mask and the low address bits used for matching
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid[i]     = {1'b0, PW'(PW'(i) - rd_ptr)} < count;
            e_addr_lo[i] = e_addr[i][AW-1:0];
        end
    end

    store_buffer_match #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW),
        .PW    (PW)
    ) u_match (
        .entry_addr  (e_addr_lo),
        .entry_data  (e_data),
        .valid       (valid),
        .rd_ptr      (rd_ptr),
        .count       (count),
        .lookup_addr (MEM_A[AW-1:0]),
        .hit         (hit),
        .data        (fwd_data)
    );

    assign full     = (count == (PW+1)'(DEPTH));
    assign nonempty = (count != '0);

`ifdef STORE_BUFFER_FWD_EN
    // Loads own the port; a hit is served from the buffer and never stalls
    always_comb begin
        drain  = nonempty & DM_GNT & ~MEM_RE;
        STALL  = (MEM_WE & full & ~drain) | (MEM_RE & ~DM_GNT & ~hit);
        MEM_RD = hit ? fwd_data : DM_RD;
    end
`else
    logic unused_fwd_data;
    assign unused_fwd_data = ^fwd_data;

    // Without forwarding a matching load waits; the head keeps draining so the match clears
    always_comb begin
        drain  = nonempty & DM_GNT & (~MEM_RE | hit);
        STALL  = (MEM_WE & full & ~drain) | (MEM_RE & (hit | ~DM_GNT));
        MEM_RD = DM_RD;
    end
`endif

    // A non-stalled store always has room: either not full or the head retires this cycle
    assign push = MEM_WE & ~STALL;

    // Memory port: head entry while draining, otherwise the core address
    always_comb begin
        DM_WE = drain;
        DM_A  = drain ? e_addr[rd_ptr] : MEM_A;
        DM_WD = e_data[rd_ptr];
    end

    assign EMPTY = ~nonempty;

    // Pointer and occupancy update
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (drain)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !drain)
                count <= count + 1'b1;
            else if (drain && !push)
                count <= count - 1'b1;
        end
    end

    // Entry storage is intentionally not reset; occupancy alone defines validity
    always_ff @(posedge CLK) begin
        if (RST_N && push) begin
            e_addr[wr_ptr] <= MEM_A;
            e_data[wr_ptr] <= MEM_WD;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

    logic        CLK;
    logic        RST_N;
    logic        MEM_RE;
    logic        MEM_WE;
    logic [31:0] MEM_A;
    logic [31:0] MEM_WD;
    logic [31:0] MEM_RD;
    logic        STALL;
    logic        EMPTY;
    logic        DM_GNT;
    logic        DM_WE;
    logic [31:0] DM_A;
    logic [31:0] DM_WD;
    logic [31:0] DM_RD;

    logic [31:0] mem [8];
    logic        init_mem;

    int n_cmp;
    int n_err;

    store_buffer dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .MEM_RE (MEM_RE),
        .MEM_WE (MEM_WE),
        .MEM_A  (MEM_A),
        .MEM_WD (MEM_WD),
        .MEM_RD (MEM_RD),
        .STALL  (STALL),
        .EMPTY  (EMPTY),
        .DM_GNT (DM_GNT),
        .DM_WE  (DM_WE),
        .DM_A   (DM_A),
        .DM_WD  (DM_WD),
        .DM_RD  (DM_RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign DM_RD = mem[DM_A[2:0]];

    always @(posedge CLK) begin
        if (init_mem) begin
            for (int i = 0; i < 8; i++) mem[i] <= 32'hF000_0000 + i;
        end else if (DM_WE) begin
            mem[DM_A[2:0]] <= DM_WD;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; MEM_RE = 1'b0; MEM_WE = 1'b0; DM_GNT = 1'b0;
        MEM_A = '0; MEM_WD = '0; init_mem = 1'b1;
        cyc(); cyc();
        init_mem = 1'b0;
        @(negedge CLK);
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", EMPTY); end
        n_cmp++; if (DM_WE !== 1'b0) begin n_err++; $display("FAIL reset_dm_we got %b want 0", DM_WE); end
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", STALL); end
        cyc();
    endtask

    task automatic test_single_store();
        RST_N = 1'b1; DM_GNT = 1'b1;
        MEM_WE = 1'b1; MEM_A = 32'd2; MEM_WD = 32'hAABB_0001;
        @(negedge CLK);
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL single_stall got %b want 0", STALL); end
        n_cmp++; if (DM_WE !== 1'b0) begin n_err++; $display("FAIL single_no_drain got %b want 0", DM_WE); end
        cyc();
        MEM_WE = 1'b0;
        @(negedge CLK);
        n_cmp++; if (DM_WE !== 1'b1) begin n_err++; $display("FAIL single_dm_we got %b want 1", DM_WE); end
        n_cmp++; if (DM_A !== 32'd2) begin n_err++; $display("FAIL single_dm_a got %h want 2", DM_A); end
        n_cmp++; if (DM_WD !== 32'hAABB_0001) begin n_err++; $display("FAIL single_dm_wd got %h want aabb0001", DM_WD); end
        n_cmp++; if (EMPTY !== 1'b0) begin n_err++; $display("FAIL single_pending got %b want 0", EMPTY); end
        cyc();
        @(negedge CLK);
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL single_empty got %b want 1", EMPTY); end
        n_cmp++; if (mem[2] !== 32'hAABB_0001) begin n_err++; $display("FAIL single_mem got %h want aabb0001", mem[2]); end
        cyc();
    endtask

    task automatic test_full_order();
        DM_GNT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MEM_WE = 1'b1; MEM_A = i; MEM_WD = 32'h100 + i;
            @(negedge CLK);
            n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL fill_stall[%0d] got %b want 0", i, STALL); end
            cyc();
        end
        MEM_A = 32'd4; MEM_WD = 32'h104;
        @(negedge CLK);
        n_cmp++; if (STALL !== 1'b1) begin n_err++; $display("FAIL full_stall got %b want 1", STALL); end
        cyc();
        DM_GNT = 1'b1;
        @(negedge CLK);
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL full_accept_stall got %b want 0", STALL); end
        n_cmp++; if (DM_A !== 32'd0) begin n_err++; $display("FAIL full_drain_a[0] got %h want 0", DM_A); end
        n_cmp++; if (DM_WD !== 32'h100) begin n_err++; $display("FAIL full_drain_wd[0] got %h want 100", DM_WD); end
        cyc();
        MEM_WE = 1'b0;
        for (int j = 1; j < 5; j++) begin
            @(negedge CLK);
            n_cmp++; if (DM_WE !== 1'b1) begin n_err++; $display("FAIL full_drain_we[%0d] got %b want 1", j, DM_WE); end
            n_cmp++; if (DM_A !== j) begin n_err++; $display("FAIL full_drain_a[%0d] got %h want %h", j, DM_A, j); end
            n_cmp++; if (DM_WD !== 32'h100 + j) begin n_err++; $display("FAIL full_drain_wd[%0d] got %h want %h", j, DM_WD, 32'h100 + j); end
            cyc();
        end
        @(negedge CLK);
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL full_empty got %b want 1", EMPTY); end
        n_cmp++; if (mem[4] !== 32'h104) begin n_err++; $display("FAIL full_mem4 got %h want 104", mem[4]); end
        cyc();
    endtask

    task automatic test_forward();
        DM_GNT = 1'b0;
        MEM_WE = 1'b1; MEM_A = 32'd5; MEM_WD = 32'h11;
        cyc();
        MEM_WD = 32'h22;
        cyc();
        MEM_WE = 1'b0; MEM_RE = 1'b1; MEM_A = 32'd5;
`ifdef STORE_BUFFER_FWD_EN
        @(negedge CLK);
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL fwd_stall got %b want 0", STALL); end
        n_cmp++; if (MEM_RD !== 32'h22) begin n_err++; $display("FAIL fwd_rd got %h want 22", MEM_RD); end
        n_cmp++; if (DM_WE !== 1'b0) begin n_err++; $display("FAIL fwd_dm_we got %b want 0", DM_WE); end
        cyc();
        MEM_RE = 1'b0; DM_GNT = 1'b1;
        @(negedge CLK);
        n_cmp++; if (DM_WD !== 32'h11) begin n_err++; $display("FAIL fwd_drain0 got %h want 11", DM_WD); end
        cyc();
        @(negedge CLK);
        n_cmp++; if (DM_WD !== 32'h22) begin n_err++; $display("FAIL fwd_drain1 got %h want 22", DM_WD); end
        cyc();
`else
        @(negedge CLK);
        n_cmp++; if (STALL !== 1'b1) begin n_err++; $display("FAIL nofwd_stall0 got %b want 1", STALL); end
        cyc();
        DM_GNT = 1'b1;
        @(negedge CLK);
        n_cmp++; if (STALL !== 1'b1) begin n_err++; $display("FAIL nofwd_stall1 got %b want 1", STALL); end
        n_cmp++; if (DM_WE !== 1'b1) begin n_err++; $display("FAIL nofwd_drain0_we got %b want 1", DM_WE); end
        n_cmp++; if (DM_WD !== 32'h11) begin n_err++; $display("FAIL nofwd_drain0 got %h want 11", DM_WD); end
        cyc();
        @(negedge CLK);
        n_cmp++; if (STALL !== 1'b1) begin n_err++; $display("FAIL nofwd_stall2 got %b want 1", STALL); end
        n_cmp++; if (DM_WD !== 32'h22) begin n_err++; $display("FAIL nofwd_drain1 got %h want 22", DM_WD); end
        cyc();
        @(negedge CLK);
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL nofwd_release got %b want 0", STALL); end
        n_cmp++; if (MEM_RD !== 32'h22) begin n_err++; $display("FAIL nofwd_rd got %h want 22", MEM_RD); end
        n_cmp++; if (DM_WE !== 1'b0) begin n_err++; $display("FAIL nofwd_dm_we got %b want 0", DM_WE); end
        cyc();
        MEM_RE = 1'b0;
`endif
        @(negedge CLK);
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL fwd_empty got %b want 1", EMPTY); end
        n_cmp++; if (mem[5] !== 32'h22) begin n_err++; $display("FAIL fwd_mem5 got %h want 22", mem[5]); end
        cyc();
    endtask

    task automatic test_load_no_drain();
        DM_GNT = 1'b0;
        MEM_WE = 1'b1; MEM_A = 32'd6; MEM_WD = 32'h66;
        cyc();
        MEM_WE = 1'b0; MEM_RE = 1'b1; MEM_A = 32'd7; DM_GNT = 1'b1;
        @(negedge CLK);
        n_cmp++; if (DM_WE !== 1'b0) begin n_err++; $display("FAIL ld_no_drain got %b want 0", DM_WE); end
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL ld_stall got %b want 0", STALL); end
        n_cmp++; if (DM_A !== 32'd7) begin n_err++; $display("FAIL ld_dm_a got %h want 7", DM_A); end
        n_cmp++; if (MEM_RD !== 32'hF000_0007) begin n_err++; $display("FAIL ld_rd got %h want f0000007", MEM_RD); end
        cyc();
        MEM_RE = 1'b0;
        @(negedge CLK);
        n_cmp++; if (DM_WE !== 1'b1) begin n_err++; $display("FAIL ld_then_drain got %b want 1", DM_WE); end
        n_cmp++; if (DM_A !== 32'd6) begin n_err++; $display("FAIL ld_then_drain_a got %h want 6", DM_A); end
        n_cmp++; if (DM_WD !== 32'h66) begin n_err++; $display("FAIL ld_then_drain_wd got %h want 66", DM_WD); end
        cyc();
        @(negedge CLK);
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL ld_empty got %b want 1", EMPTY); end
        cyc();
    endtask

    task automatic test_back_to_back();
        DM_GNT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MEM_WE = 1'b1; MEM_A = i; MEM_WD = 32'h200 + i;
            cyc();
        end
        DM_GNT = 1'b1; MEM_A = 32'd4; MEM_WD = 32'h204;
        @(negedge CLK);
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL b2b_stall got %b want 0", STALL); end
        n_cmp++; if (DM_WE !== 1'b1) begin n_err++; $display("FAIL b2b_dm_we got %b want 1", DM_WE); end
        n_cmp++; if (DM_A !== 32'd0) begin n_err++; $display("FAIL b2b_dm_a got %h want 0", DM_A); end
        cyc();
        DM_GNT = 1'b0; MEM_A = 32'd5; MEM_WD = 32'h205;
        @(negedge CLK);
        n_cmp++; if (STALL !== 1'b1) begin n_err++; $display("FAIL b2b_still_full got %b want 1", STALL); end
        cyc();
        MEM_WE = 1'b0; DM_GNT = 1'b1;
        for (int j = 1; j < 5; j++) begin
            @(negedge CLK);
            n_cmp++; if (DM_A !== j) begin n_err++; $display("FAIL b2b_order_a[%0d] got %h want %h", j, DM_A, j); end
            n_cmp++; if (DM_WD !== 32'h200 + j) begin n_err++; $display("FAIL b2b_order_wd[%0d] got %h want %h", j, DM_WD, 32'h200 + j); end
            cyc();
        end
        @(negedge CLK);
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL b2b_empty got %b want 1", EMPTY); end
        cyc();
    endtask

    task automatic test_reset_mid();
        DM_GNT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MEM_WE = 1'b1; MEM_A = i; MEM_WD = 32'hDEAD_0000 + i;
            cyc();
        end
        MEM_WE = 1'b0;
        @(negedge CLK);
        n_cmp++; if (EMPTY !== 1'b0) begin n_err++; $display("FAIL rst_mid_pending got %b want 0", EMPTY); end
        cyc();
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1; DM_GNT = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_cmp++; if (DM_WE !== 1'b0) begin n_err++; $display("FAIL rst_mid_dm_we[%0d] got %b want 0", k, DM_WE); end
            n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL rst_mid_empty[%0d] got %b want 1", k, EMPTY); end
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (mem[i] !== 32'h200 + i) begin n_err++; $display("FAIL rst_mid_mem[%0d] got %h want %h", i, mem[i], 32'h200 + i); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_store();
        test_full_order();
        test_forward();
        test_load_no_drain();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
